// File: rtl/decrypt_pkg.sv
// Shared definitions for the 60-bit payload encrypt/decrypt pair: frame layout,
// mode and state encodings, and the keystream/permutation helpers.
package decrypt_pkg;

  localparam int DATA_W  = 60;
  localparam int FRAME_W = 78;
  localparam int K6_W    = 6;
  localparam int K11_W   = 11;

  localparam int PARITY_POS = 77;
  localparam int K6_LSB     = 71;
  localparam int K11_LSB    = 60;
  localparam int CIPHER_LSB = 0;

  localparam logic [K6_W-1:0] ROT_MOD = 6'd60;

  typedef enum logic [1:0] {
    MODE_XOR = 2'd0,
    MODE_ROT = 2'd1,
    MODE_SUB = 2'd2,
    MODE_REV = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ROT,
    ST_FINISH,
    ST_DONE
  } state_e;

  function automatic logic [DATA_W-1:0] make_keystream(input logic [K6_W-1:0]  k6,
                                                       input logic [K11_W-1:0] k11);
    return {k11, k6, k11, k6, k11, k6, k11[10:2]};
  endfunction

  // k6 values 60..63 wrap onto 0..3.
  function automatic logic [K6_W-1:0] rot_amount(input logic [K6_W-1:0] k6);
    return (k6 >= ROT_MOD) ? k6 - ROT_MOD : k6;
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                             input logic [K6_W-1:0]   amt);
    logic [2*DATA_W-1:0] dbl;
    dbl = {x, x} >> amt;
    return dbl[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    y = '0;
    for (int i = 0; i < DATA_W; i++) begin
      y[i] = x[DATA_W-1-i];
    end
    return y;
  endfunction

endpackage

// File: rtl/frame_parity_check.sv
// XOR reduction over a full frame; 1 means odd parity. The encrypt side feeds
// the frame with bit 77 cleared to generate the parity bit.
module frame_parity_check
  import decrypt_pkg::*;
(
  input  logic [FRAME_W-1:0] frame,
  output logic               odd_parity
);

  assign odd_parity = ^frame;

endmodule

// File: rtl/frame_decrypter.sv
// Receiver-side frame decrypter: parity check, key-selected inverse transform,
// and a multi-cycle rotate, with one frame in flight between two handshakes.
module frame_decrypter
  import decrypt_pkg::*;
#(
  parameter bit          CHECK_PARITY = 1'b1,
  parameter int unsigned ROT_STEP     = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAME_W-1:0] data_to_be_decrypt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  output_decrypted,
  output logic               parity_error
);

  localparam logic [K6_W-1:0] STEP_MAX = K6_W'(ROT_STEP);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [DATA_W-1:0]  work_q, work_d;
  logic [K6_W-1:0]    rem_q, rem_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               parity_error_q, parity_error_d;

  logic [K6_W-1:0]    k6;
  logic [K11_W-1:0]   k11;
  logic [DATA_W-1:0]  cipher;
  logic [DATA_W-1:0]  keystream;
  mode_e              mode;
  logic [K6_W-1:0]    rot_r;
  logic [K6_W-1:0]    step;
  logic               frame_odd;
  logic               parity_fail;

  // Key fields stay valid all through the operation because the frame is held.
  assign k6        = frame_q[K6_LSB +: K6_W];
  assign k11       = frame_q[K11_LSB +: K11_W];
  assign cipher    = frame_q[CIPHER_LSB +: DATA_W];
  assign keystream = make_keystream(k6, k11);
  assign mode      = mode_e'(k6[1:0]);
  assign rot_r     = rot_amount(k6);

  frame_parity_check u_parity (
    .frame      (frame_q),
    .odd_parity (frame_odd)
  );

  assign parity_fail = CHECK_PARITY && frame_odd;
  assign step        = (rem_q < STEP_MAX) ? rem_q : STEP_MAX;

  always_comb begin
    // NOTE: every _d takes its _q value first, so branches that leave a signal
    // untouched hold it instead of inferring a latch.
    state_d        = state_q;
    frame_d        = frame_q;
    work_d         = work_q;
    rem_d          = rem_q;
    out_valid_d    = out_valid_q;
    result_d       = result_q;
    parity_error_d = parity_error_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          frame_d = data_to_be_decrypt;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (parity_fail) begin
          result_d       = '0;
          parity_error_d = 1'b1;
          out_valid_d    = 1'b1;
          state_d        = ST_DONE;
        end else begin
          work_d  = (mode == MODE_SUB) ? cipher - keystream : cipher ^ keystream;
          rem_d   = rot_r;
          state_d = (mode == MODE_ROT && rot_r != '0) ? ST_ROT : ST_FINISH;
        end
      end
      ST_ROT: begin
        // The last step may be shorter than ROT_STEP so the total is exactly r.
        work_d = rotr(work_q, step);
        rem_d  = rem_q - step;
        if (rem_q == step) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        result_d       = (mode == MODE_REV) ? bit_reverse(work_q) : work_q;
        parity_error_d = 1'b0;
        out_valid_d    = 1'b1;
        state_d        = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q        <= ST_IDLE;
      frame_q        <= '0;
      work_q         <= '0;
      rem_q          <= '0;
      out_valid_q    <= 1'b0;
      result_q       <= '0;
      parity_error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q        <= state_d;
      frame_q        <= frame_d;
      work_q         <= work_d;
      rem_q          <= rem_d;
      out_valid_q    <= out_valid_d;
      result_q       <= result_d;
      parity_error_q <= parity_error_d;
    end
  end

  // Accepting only from IDLE means a result is never consumed and replaced in one cycle.
  assign in_ready         = (state_q == ST_IDLE);
  assign out_valid        = out_valid_q;
  assign output_decrypted = result_q;
  assign parity_error     = parity_error_q;

endmodule
